host_run_launcher: RTL and testbench
====================================

Name: host_run_launcher

Overview:
- Initiator side of the core's start/ack run handshake.
- Each run: pulses the core's reset, holds start high, then drops it. Waits for ack, counts run cycles and enforces a cycle-budget timeout.
- Reports one result per run: cycle count, timeout flag, total completed runs.
- Sits beside the processor top level in the FPGA/sim harness, replacing hand-written bench sequencing.

Parameters:
- RESET_CYCLES, 2, cycles dut_reset is held high per run (>=1)
- START_HOLD, 2, cycles dut_start is held high after reset release (>=1)
- TIMEOUT, 4096, RUN cycles allowed before the run is declared timed out (>=1, < 2^CNT_W)
- CNT_W, 16, width of cycle and run counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- go  in  1  request a run; sampled only in IDLE
- dut_ack  in  1  ack from core (done or core overflow)
- dut_reset  out  1  reset to core
- dut_start  out  1  start to core
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle pulse when a run finishes
- result_cycles  out  CNT_W  RUN-phase cycle count of last run
- result_timeout  out  1  last run ended by timeout, not ack
- run_count  out  CNT_W  completed runs since reset; includes timed-out runs

Behaviour:
- All outputs registered; Moore outputs decoded from state.
- Reset values: dut_reset=0, dut_start=0, busy=0, result_valid=0, result_cycles=0, result_timeout=0, run_count=0, state=IDLE.
- States: IDLE -> RST -> START -> RUN -> DONE -> IDLE.
- IDLE:
  - dut_reset=0, dut_start=0.
  - go=1 -> RST next cycle; the phase counter is loaded.
  - go=0 -> stay.
- RST:
  - dut_reset=1, dut_start=0 for exactly RESET_CYCLES cycles, then START.
- START:
  - dut_start=1, dut_reset=0 for exactly START_HOLD cycles, then RUN.
- RUN:
  - dut_start=0. cyc counter cleared on entry, increments every RUN cycle; the first RUN cycle counts as 1.
  - dut_ack=1 sampled in a RUN cycle -> DONE. Captured cycles = count including that cycle.
  - Otherwise, when cyc reaches TIMEOUT -> DONE with timeout=1, cycles=TIMEOUT.
  - If ack and the TIMEOUT-th cycle coincide, ack wins: timeout=0, cycles=TIMEOUT.
- DONE:
  - One cycle only: result_valid=1, busy=1.
  - result_cycles and result_timeout are updated on DONE entry and hold until the next DONE.
  - run_count increments on DONE entry and wraps at 2^CNT_W.
  - Next state IDLE unconditionally.
- Ack and go rules:
  - dut_ack is ignored in IDLE, RST, START and DONE. This covers stale ack left high from a previous run.
  - go is ignored while busy. There is no queuing; go must be re-asserted in IDLE.
  - go held continuously -> back-to-back runs with exactly one IDLE cycle between DONE and RST.
- Reset mid-operation:
  - Any state returns to IDLE next cycle with all outputs at reset values.
  - The partial run produces no result and does not count.
- Latency: go sampled at IDLE cycle t -> dut_reset high from t+1; dut_start high from t+1+RESET_CYCLES; first RUN cycle t+1+RESET_CYCLES+START_HOLD.
- Counters: cyc never exceeds TIMEOUT; no overflow logic needed beyond that bound.

Test Plan:
- Defaults, go pulse at cycle 10; core model raises ack on its 37th RUN cycle -> dut_reset high cycles 11-12, dut_start high 13-14; result_valid pulse; result_cycles=37, result_timeout=0, run_count=1.
- Core never acks -> after 4096 RUN cycles result_valid pulses, result_timeout=1, result_cycles=4096, run_count=1.
- dut_ack held high during RST and START, dropped at RUN entry, re-raised on RUN cycle 5 -> result_cycles=5, not 0 or 1.
- Ack raised exactly on RUN cycle 4096 -> result_timeout=0, result_cycles=4096.
- go held high for 3 runs with acks at 3, 8, 1 RUN cycles:
  - result_cycles sequence 3, 8, 1; run_count 1, 2, 3.
  - Exactly one IDLE cycle between each DONE and the next RST.
  - Extra go pulses while busy are ignored.
- reset asserted on RUN cycle 20 of a run -> next cycle all outputs at reset values, run_count=0. A subsequent go/ack-at-4 run reports result_cycles=4, run_count=1.

Source files
------------

// File: rtl/host_run_launcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | host_run_launcher                                                      |
// | Initiator side of the core start/ack run handshake with cycle budget.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module host_run_launcher #(
  parameter int RESET_CYCLES = 2,
  parameter int START_HOLD   = 2,
  parameter int TIMEOUT      = 4096,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             dut_ack,
  output logic             dut_reset,
  output logic             dut_start,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_cycles,
  output logic             result_timeout,
  output logic [CNT_W-1:0] run_count
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_rst   = 3'd1;
  localparam logic [2:0] c_start = 3'd2;
  localparam logic [2:0] c_run   = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  localparam logic [CNT_W-1:0] c_rst_load   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_start_load = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] w_cyc_inc;

  // w_cyc_inc is the count including the current RUN cycle.
  always_comb begin
    w_cyc_inc = r_cyc + c_one;
    w_next    = r_state;
    case (r_state)
      c_idle:  if (go) w_next = c_rst;
      c_rst:   if (r_phase == '0) w_next = c_start;
      c_start: if (r_phase == '0) w_next = c_run;
      c_run:   if (dut_ack || (w_cyc_inc == c_timeout)) w_next = c_done;
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Outputs are registered decodes of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= c_idle;
      r_phase        <= '0;
      r_cyc          <= '0;
      dut_reset      <= 1'b0;
      dut_start      <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      run_count      <= '0;
    end else begin
      r_state      <= w_next;
      dut_reset    <= (w_next == c_rst);
      dut_start    <= (w_next == c_start);
      busy         <= (w_next != c_idle);
      result_valid <= (w_next == c_done);

      case (r_state)
        c_idle: begin
          r_phase <= c_rst_load;
        end
        c_rst: begin
          if (r_phase == '0) begin
            r_phase <= c_start_load;
          end else begin
            r_phase <= r_phase - c_one;
          end
        end
        c_start: begin
          r_cyc <= '0;
          if (r_phase != '0) begin
            r_phase <= r_phase - c_one;
          end
        end
        c_run: begin
          r_cyc <= w_cyc_inc;
          if (w_next == c_done) begin
            result_cycles  <= w_cyc_inc;
            result_timeout <= ~dut_ack;
            run_count      <= run_count + c_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_host_run_launcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_host_run_launcher                                                   |
// | Scoreboard bench: driver pushes expected results, monitor pops them.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_host_run_launcher;

  localparam int R = 2;
  localparam int S = 2;
  localparam int T = 4096;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         go = 1'b0;
  logic         dut_ack = 1'b0;
  logic         dut_reset;
  logic         dut_start;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] result_cycles;
  logic         result_timeout;
  logic [W-1:0] run_count;

  host_run_launcher #(
    .RESET_CYCLES(R),
    .START_HOLD  (S),
    .TIMEOUT     (T),
    .CNT_W       (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .dut_ack       (dut_ack),
    .dut_reset     (dut_reset),
    .dut_start     (dut_start),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_cycles (result_cycles),
    .result_timeout(result_timeout),
    .run_count     (run_count)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int cycles;
    bit to;
    int cnt;
    int done;
  } exp_t;

  exp_t q[$];
  int   model_count = 0;
  int   last_done = -1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  exp_t e;
  always @(negedge clk) begin
    if (result_valid) begin
      if (q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        check("result_cycles", result_cycles, e.cycles);
        check("result_timeout", result_timeout, e.to);
        check("run_count", run_count, e.cnt);
        check("result_time", cycle, e.done);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    go = 1'b0;
    dut_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dut_reset", dut_reset, 0);
    check("rst_dut_start", dut_start, 0);
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_cycles", result_cycles, 0);
    check("rst_result_timeout", result_timeout, 0);
    check("rst_run_count", run_count, 0);
    check("pending_results", q.size(), 0);
    reset = 1'b0;
    model_count = 0;
    last_done = -1;
  endtask

  // k: RUN cycle on which the core acks (0 = never); stale: 0 none,
  // 1 ack held high outside RUN, 2 random ack outside RUN; hold: go kept high;
  // gap: extra idle cycles; abort_at: RUN cycle on which reset is asserted.
  task automatic run_once(input int k, input int stale, input bit hold,
                          input int gap, input int abort_at);
    int t, fr, ncyc, done, c_end, guard;
    bit to, wave_ok, exp_rst, exp_st, exp_valid;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      check("idle_wait_timeout", 1, 0);
      return;
    end
    if (last_done >= 0) check("idle_after_done", cycle - last_done, 1);
    check("idle_outputs", {dut_reset, dut_start, result_valid}, 0);
    repeat (gap) begin
      go = 1'b0;
      dut_ack = 1'($urandom % 2);
      @(negedge clk);
    end
    t = cycle;
    go = 1'b1;
    to = !(k > 0 && k <= T);
    ncyc = to ? T : k;
    fr = t + R + S + 1;
    done = fr + ncyc;
    dut_ack = (stale == 1) ? 1'b1 : (stale == 2) ? 1'($urandom % 2) : 1'b0;
    if (abort_at == 0) begin
      model_count = (model_count + 1) % (1 << W);
      q.push_back('{ncyc, to, model_count, done});
      c_end = done;
    end else begin
      c_end = fr + abort_at - 1;
    end
    wave_ok = 1'b1;
    for (int c = t + 1; c <= c_end; c++) begin
      @(negedge clk);
      exp_rst   = (c <= t + R);
      exp_st    = (c > t + R) && (c <= t + R + S);
      exp_valid = (c == done);
      if (wave_ok && ({dut_reset, dut_start, busy, result_valid} !=
                      {exp_rst, exp_st, 1'b1, exp_valid})) begin
        wave_ok = 1'b0;
        $display("FAIL waveform at cycle %0d: got rst/start/busy/valid=%b expected %b",
                 c, {dut_reset, dut_start, busy, result_valid},
                 {exp_rst, exp_st, 1'b1, exp_valid});
      end
      go = hold ? 1'b1 : 1'($urandom % 4 == 0);
      if (c < fr || c >= done)
        dut_ack = (stale == 1) ? 1'b1 : (stale == 2) ? 1'($urandom % 2) : 1'b0;
      else
        dut_ack = (c - fr + 1 == k);
    end
    tests++;
    if (!wave_ok) fails++;
    if (abort_at != 0) begin
      reset = 1'b1;
      @(negedge clk);
      check("abort_outputs", {dut_reset, dut_start, busy, result_valid,
                              result_timeout, result_cycles}, 0);
      check("abort_run_count", run_count, 0);
      reset = 1'b0;
      go = 1'b0;
      dut_ack = 1'b0;
      model_count = 0;
      last_done = -1;
    end else begin
      last_done = done;
    end
  endtask

  initial begin
    @(negedge clk);
    check("init_dut_reset", dut_reset, 0);
    check("init_busy", busy, 0);
    check("init_run_count", run_count, 0);
    do_reset();
    // go sampled on cycle 10, ack on RUN cycle 37
    while (cycle < 9) @(negedge clk);
    run_once(37, 0, 0, 0, 0);
    do_reset();
    run_once(0, 0, 0, 0, 0);
    do_reset();
    run_once(5, 1, 0, 0, 0);
    do_reset();
    run_once(4096, 0, 0, 1, 0);
    do_reset();
    run_once(3, 0, 1, 0, 0);
    run_once(8, 0, 1, 0, 0);
    run_once(1, 0, 1, 0, 0);
    do_reset();
    run_once(0, 0, 0, 0, 20);
    run_once(4, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      run_once(int'($urandom_range(1, 60)), int'($urandom_range(0, 2)),
               1'($urandom % 2), int'($urandom_range(0, 3)), 0);
    end
    go = 1'b0;
    dut_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("pending_results", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
